// File: rtl/gbf_pkg.sv
// Shared constants, per-port request record and circular index helper for the GBF port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gbf_pkg;

    localparam int NUM_PORTS = 4;

    // Upper bounds for the generic port record; instances zero-fill above their own widths.
    localparam int MAX_AW    = 16;
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic                 we;
        logic [MAX_AW-1:0]    addr;
        logic [MAX_WIDTH-1:0] data;
    } port_req_t;

    // (base + off) mod n, for base < n and off < n; a compare and subtract, no divider.
    function automatic int unsigned circ_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/gbf_port_arbiter_if.sv
// Requester and RAM-port bundle of the GBF port arbiter.
// Latency: n/a (wires only). slave = arbiter side, master = requesters plus RAM.
// Backpressure: req_ready gates each requester; the RAM side has none.
interface gbf_port_arbiter_if
    import gbf_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 48,
    parameter int N_REQ  = 8
);
    localparam int AW = $clog2(HEIGHT);

    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_we;
    logic [N_REQ*AW-1:0]        req_addr;
    logic [N_REQ*WIDTH-1:0]     req_wdata;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ-1:0]           rsp_valid;
    logic [N_REQ*WIDTH-1:0]     rsp_rdata;
    logic [NUM_PORTS-1:0]       ram_we;
    logic [NUM_PORTS*AW-1:0]    ram_addr;
    logic [NUM_PORTS*WIDTH-1:0] ram_data;
    logic [NUM_PORTS*WIDTH-1:0] ram_q;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_q,
        output req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_q,
        input  req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_data
    );

endinterface

// File: rtl/gbf_rr_allocator.sv
// Round-robin scan mapping up to four requests onto RAM ports a..d, blocking same-address writes.
// Latency: purely combinational.
// Backpressure: requests beyond four ports or hitting an earlier write address are simply not granted.
module gbf_rr_allocator
    import gbf_pkg::*;
#(
    parameter int N_REQ  = 8,
    parameter int HEIGHT = 48,
    parameter int AW     = 6,
    parameter int PW     = $clog2(N_REQ)
) (
    input  logic [PW-1:0]                 rr_ptr,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0]              req_we,
    input  logic [N_REQ*AW-1:0]           req_addr,
    output logic [N_REQ-1:0]              grant,
    output logic [N_REQ-1:0]              conflict,
    output logic [NUM_PORTS-1:0]          port_vld,
    output logic [NUM_PORTS-1:0][PW-1:0]  port_idx,
    output logic                          any_grant,
    output logic [PW-1:0]                 last_idx
);
    localparam logic [AW:0] HEIGHT_W = (AW+1)'(HEIGHT);

    logic [2:0]                   taken;
    logic [NUM_PORTS-1:0]         wr_vld;
    logic [NUM_PORTS-1:0][AW-1:0] wr_addr;
    logic [PW-1:0]                idx;
    logic [AW-1:0]                addr;
    logic                         hit;

    always_comb begin
        grant    = '0;
        conflict = '0;
        port_vld = '0;
        port_idx = '0;
        wr_vld   = '0;
        wr_addr  = '0;
        taken    = '0;
        idx      = '0;
        addr     = '0;
        hit      = 1'b0;
        last_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx  = PW'(circ_add(32'(rr_ptr), k, N_REQ));
            addr = req_addr[idx*AW +: AW];
            // Only in-range granted writes are recorded, so a hit always means a real RAM collision.
            hit  = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_vld[p] && (wr_addr[p] == addr)) begin
                    hit = 1'b1;
                end
            end
            // A conflict is counted only when a port was still free: the address clash,
            // not port exhaustion, is what holds that write back.
            if (req_valid[idx] && (taken < 3'(NUM_PORTS))) begin
                if (req_we[idx] && hit) begin
                    conflict[idx] = 1'b1;
                end else begin
                    grant[idx]             = 1'b1;
                    port_vld[taken[1:0]]   = 1'b1;
                    port_idx[taken[1:0]]   = idx;
                    last_idx               = idx;
                    if (req_we[idx] && ({1'b0, addr} < HEIGHT_W)) begin
                        wr_vld[taken[1:0]]  = 1'b1;
                        wr_addr[taken[1:0]] = addr;
                    end
                    taken = taken + 3'd1;
                end
            end
        end
    end

    assign any_grant = |grant;

endmodule

// File: rtl/gbf_port_arbiter.sv
// Shares the four GBF RAM ports among N_REQ requesters round-robin; ports clk, rst_n, bus (slave), conflict_cnt.
// Latency: grant and RAM port drive same cycle; read data registered, rsp_valid one cycle after grant.
// Backpressure: req_ready low when all ports are taken or a write would hit an address already written this cycle.
module gbf_port_arbiter
    import gbf_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int HEIGHT = 48,
    parameter  int N_REQ  = 8,
    localparam int AW     = $clog2(HEIGHT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    gbf_port_arbiter_if.slave        bus,
    output logic [15:0]              conflict_cnt
);
    localparam int          PW       = $clog2(N_REQ);
    localparam int          CW       = $clog2(N_REQ + 1);
    localparam logic [AW:0] HEIGHT_W = (AW+1)'(HEIGHT);

    logic [PW-1:0]                rr_ptr;
    logic [N_REQ-1:0]             grant;
    logic [N_REQ-1:0]             conflict;
    logic [NUM_PORTS-1:0]         port_vld;
    logic [NUM_PORTS-1:0][PW-1:0] port_idx;
    logic                         any_grant;
    logic [PW-1:0]                last_idx;

    port_req_t [NUM_PORTS-1:0]    preq;
    logic [NUM_PORTS-1:0]         port_rd;
    logic [NUM_PORTS-1:0]         port_inr;
    logic [PW-1:0]                pi;
    logic [AW-1:0]                pa;
    logic                         pinr;
    logic                         unused_hi;

    logic [N_REQ-1:0]             rsp_valid_q, rsp_valid_nxt;
    logic [N_REQ*WIDTH-1:0]       rsp_rdata_q, rsp_rdata_nxt;
    logic [CW-1:0]                n_conf;
    logic [16:0]                  cnt_sum;
    logic [15:0]                  cnt_nxt;
    logic [PW-1:0]                ptr_nxt;

    gbf_rr_allocator #(
        .N_REQ  (N_REQ),
        .HEIGHT (HEIGHT),
        .AW     (AW),
        .PW     (PW)
    ) u_alloc (
        .rr_ptr    (rr_ptr),
        .req_valid (bus.req_valid),
        .req_we    (bus.req_we),
        .req_addr  (bus.req_addr),
        .grant     (grant),
        .conflict  (conflict),
        .port_vld  (port_vld),
        .port_idx  (port_idx),
        .any_grant (any_grant),
        .last_idx  (last_idx)
    );

    assign bus.req_ready = grant & {N_REQ{rst_n}};

    // Gather the granted request for each port; out-of-range writes keep we low (dropped).
    always_comb begin
        preq     = '0;
        port_rd  = '0;
        port_inr = '0;
        pi       = '0;
        pa       = '0;
        pinr     = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pi   = port_idx[p];
            pa   = bus.req_addr[pi*AW +: AW];
            pinr = ({1'b0, pa} < HEIGHT_W);
            if (port_vld[p]) begin
                preq[p].addr = MAX_AW'(pa);
                if (bus.req_we[pi]) begin
                    preq[p].we   = pinr;
                    preq[p].data = MAX_WIDTH'(bus.req_wdata[pi*WIDTH +: WIDTH]);
                end else begin
                    port_rd[p]  = 1'b1;
                    port_inr[p] = pinr;
                end
            end
        end
    end

    always_comb begin
        bus.ram_we   = '0;
        bus.ram_addr = '0;
        bus.ram_data = '0;
        unused_hi    = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.ram_we[p]                   = preq[p].we & rst_n;
            bus.ram_addr[p*AW +: AW]        = preq[p].addr[AW-1:0];
            bus.ram_data[p*WIDTH +: WIDTH]  = preq[p].data[WIDTH-1:0];
            // Bits above AW/WIDTH in the generic record are zero by construction.
            unused_hi = unused_hi ^ (^(preq[p].addr >> AW)) ^ (^(preq[p].data >> WIDTH));
        end
    end

    // ram_q is sampled at the same edge that commits writes, so a same-cycle read sees old data.
    always_comb begin
        rsp_valid_nxt = '0;
        rsp_rdata_nxt = rsp_rdata_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_rd[p]) begin
                rsp_valid_nxt[port_idx[p]] = 1'b1;
                rsp_rdata_nxt[port_idx[p]*WIDTH +: WIDTH] =
                    port_inr[p] ? bus.ram_q[p*WIDTH +: WIDTH] : '0;
            end
        end
    end

    always_comb begin
        n_conf = '0;
        for (int i = 0; i < N_REQ; i++) begin
            n_conf = n_conf + CW'(conflict[i]);
        end
        cnt_sum = 17'(conflict_cnt) + 17'(n_conf);
        cnt_nxt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        ptr_nxt = any_grant ? PW'(circ_add(32'(last_idx), 1, N_REQ)) : rr_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            conflict_cnt <= '0;
        end else begin
            rr_ptr       <= ptr_nxt;
            rsp_valid_q  <= rsp_valid_nxt;
            rsp_rdata_q  <= rsp_rdata_nxt;
            conflict_cnt <= cnt_nxt;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_gbf_port_arbiter.sv
// Bench for gbf_port_arbiter: behavioural RAM, directed scenarios, then randomized traffic.
// Latency: expects grants same cycle and read responses one cycle later.
// Backpressure: requests are held until granted.
module tb_gbf_port_arbiter;
    import gbf_pkg::*;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 48;
    localparam int N_REQ  = 8;
    localparam int AW     = 6;
    localparam int NP     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] conflict_cnt;

    gbf_port_arbiter_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .N_REQ(N_REQ)) bus();

    gbf_port_arbiter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .N_REQ(N_REQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] init_val(input int i);
        if (i == 5) return 32'hDEAD_BEEF;
        if (i == 7) return 32'h0000_0055;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Global buffer RAM: combinational read, one synchronous write per port.
    logic [WIDTH-1:0] mem [HEIGHT];
    logic             fill_en;
    logic [AW-1:0]    fill_idx;
    logic [AW-1:0]    qa;

    always @(posedge clk) begin
        if (fill_en) mem[fill_idx] <= init_val(int'(fill_idx));
        for (int p = 0; p < NP; p++) begin
            if (bus.ram_we[p]) mem[bus.ram_addr[p*AW +: AW]] <= bus.ram_data[p*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        bus.ram_q = '0;
        qa = '0;
        for (int p = 0; p < NP; p++) begin
            qa = bus.ram_addr[p*AW +: AW];
            bus.ram_q[p*WIDTH +: WIDTH] = (int'(qa) < HEIGHT) ? mem[qa] : (32'hBAD0_0000 | 32'(qa));
        end
    end

    // Stimulus: one held request per requester.
    logic [N_REQ-1:0] s_vld, s_we;
    logic [AW-1:0]    s_addr [N_REQ];
    logic [WIDTH-1:0] s_wdat [N_REQ];

    // Reference model state.
    int               m_ptr, m_cnt, m_conf;
    int               m_order[$];
    logic [N_REQ-1:0] m_grant;
    logic [WIDTH-1:0] m_mem [64];
    logic [N_REQ-1:0] m_rsp_vld;
    logic [WIDTH-1:0] m_rsp_dat [N_REQ];

    logic [N_REQ-1:0] last_ready;
    logic [NP-1:0]    last_we;
    logic [NP*AW-1:0] last_addr;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = s_vld;
        bus.req_we    = s_we;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_addr[i*AW +: AW]        = s_addr[i];
            bus.req_wdata[i*WIDTH +: WIDTH] = s_wdat[i];
        end
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_cnt     = 0;
        m_rsp_vld = '0;
        s_vld     = '0;
    endtask

    // Visit requesters from the pointer; take up to four; refuse a write whose
    // in-range address is already being written this cycle.
    task automatic model_alloc();
        int written[$];
        m_order.delete();
        m_grant = '0;
        m_conf  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            bit dup;
            i = (m_ptr + k) % N_REQ;
            if (!s_vld[i] || m_order.size() >= NP) continue;
            dup = 1'b0;
            foreach (written[j]) if (written[j] == int'(s_addr[i])) dup = 1'b1;
            if (s_we[i] && dup) begin
                m_conf++;
                continue;
            end
            m_order.push_back(i);
            m_grant[i] = 1'b1;
            if (s_we[i] && int'(s_addr[i]) < HEIGHT) written.push_back(int'(s_addr[i]));
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        logic            exp_we;
        logic [AW-1:0]   exp_addr;
        int              i;
        drive();
        #1;
        model_alloc();
        last_ready = bus.req_ready;
        last_we    = bus.ram_we;
        last_addr  = bus.ram_addr;
        check("req_ready", bus.req_ready, m_grant);
        for (int p = 0; p < NP; p++) begin
            exp_we   = 1'b0;
            exp_addr = '0;
            if (p < m_order.size()) begin
                i        = m_order[p];
                exp_addr = s_addr[i];
                exp_we   = s_we[i] && (int'(s_addr[i]) < HEIGHT);
            end
            check("ram_we", bus.ram_we[p], exp_we);
            check("ram_addr", bus.ram_addr[p*AW +: AW], exp_addr);
            if (exp_we) check("ram_data", bus.ram_data[p*WIDTH +: WIDTH], s_wdat[m_order[p]]);
        end
        check("rsp_valid", bus.rsp_valid, m_rsp_vld);
        for (int r = 0; r < N_REQ; r++) begin
            if (m_rsp_vld[r]) check("rsp_rdata", bus.rsp_rdata[r*WIDTH +: WIDTH], m_rsp_dat[r]);
        end
        check("conflict_cnt", conflict_cnt, 64'(m_cnt));
        @(posedge clk);
        m_rsp_vld = '0;
        foreach (m_order[k]) begin
            i = m_order[k];
            if (!s_we[i]) begin
                m_rsp_vld[i] = 1'b1;
                m_rsp_dat[i] = (int'(s_addr[i]) < HEIGHT) ? m_mem[s_addr[i]] : '0;
            end
        end
        foreach (m_order[k]) begin
            i = m_order[k];
            if (s_we[i] && int'(s_addr[i]) < HEIGHT) m_mem[s_addr[i]] = s_wdat[i];
        end
        if (m_order.size() > 0) m_ptr = (m_order[m_order.size()-1] + 1) % N_REQ;
        m_cnt = (m_cnt + m_conf > 65535) ? 65535 : m_cnt + m_conf;
        s_vld = s_vld & ~m_grant;
        @(negedge clk);
    endtask

    initial begin
        fill_en  = 1'b0;
        fill_idx = '0;
        s_vld    = '0;
        s_we     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            s_addr[i] = '0;
            s_wdat[i] = '0;
        end
        drive();

        // Preload RAM while the arbiter is held in reset.
        for (int i = 0; i < HEIGHT; i++) begin
            @(negedge clk);
            fill_en  = 1'b1;
            fill_idx = AW'(i);
        end
        @(negedge clk);
        fill_en = 1'b0;
        for (int i = 0; i < 64; i++) m_mem[i] = (i < HEIGHT) ? init_val(i) : '0;

        // Reset state with every requester asking to write.
        s_vld = '1;
        s_we  = '1;
        for (int i = 0; i < N_REQ; i++) s_addr[i] = AW'(i);
        drive();
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_conflict_cnt", conflict_cnt, 0);
        for (int i = 0; i < N_REQ; i++) check("rst_rsp_rdata", bus.rsp_rdata[i*WIDTH +: WIDTH], 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // All eight read, pointer at 0: 0-3 then 4-7.
        s_vld = '1;
        s_we  = '0;
        for (int i = 0; i < N_REQ; i++) s_addr[i] = AW'(i);
        step();
        check("all8_ready0", last_ready, 8'h0F);
        check("all8_ports0", last_addr, {6'd3, 6'd2, 6'd1, 6'd0});
        step();
        check("all8_ready1", last_ready, 8'hF0);
        check("all8_rsp1", bus.rsp_valid, 8'hF0);
        check("all8_rdata5", bus.rsp_rdata[5*WIDTH +: WIDTH], 32'hDEAD_BEEF);

        // Same-address writes from 1 and 2.
        s_vld = 8'h06;
        s_we  = 8'h06;
        s_addr[1] = 6'd10; s_wdat[1] = 32'h11;
        s_addr[2] = 6'd10; s_wdat[2] = 32'h22;
        step();
        check("wconf_ready0", last_ready, 8'h02);
        check("wconf_cnt", conflict_cnt, 1);
        step();
        check("wconf_ready1", last_ready, 8'h04);
        check("wconf_mem10", mem[10], 32'h22);

        // Single read by requester 3.
        s_vld = 8'h08;
        s_we  = '0;
        s_addr[3] = 6'd5;
        step();
        check("solo_ready", last_ready, 8'h08);
        check("solo_port_a", last_addr[AW-1:0], 6'd5);
        check("solo_rsp_valid", bus.rsp_valid, 8'h08);
        check("solo_rdata", bus.rsp_rdata[3*WIDTH +: WIDTH], 32'hDEAD_BEEF);

        // Pointer now at 4: full load grants 4-7 first.
        s_vld = '1;
        s_we  = '0;
        step();
        check("ptr4_ready", last_ready, 8'hF0);
        step();
        check("ptr4_ready_next", last_ready, 8'h0F);

        // Read and write of address 7 in one cycle: old data returned.
        s_vld = 8'h03;
        s_we  = 8'h01;
        s_addr[0] = 6'd7; s_wdat[0] = 32'hAA;
        s_addr[1] = 6'd7;
        step();
        check("rw_ready", last_ready, 8'h03);
        check("rw_rsp_valid", bus.rsp_valid, 8'h02);
        check("rw_old_data", bus.rsp_rdata[1*WIDTH +: WIDTH], 32'h55);
        s_vld = 8'h02;
        step();
        check("rw_new_data", bus.rsp_rdata[1*WIDTH +: WIDTH], 32'hAA);

        // Out-of-range write and read.
        s_vld = 8'h0C;
        s_we  = 8'h04;
        s_addr[2] = 6'd50; s_wdat[2] = 32'h77;
        s_addr[3] = 6'd60;
        step();
        check("oor_ready", last_ready, 8'h0C);
        check("oor_ram_we", last_we, 0);
        check("oor_rsp_valid", bus.rsp_valid, 8'h08);
        check("oor_rdata", bus.rsp_rdata[3*WIDTH +: WIDTH], 0);

        // Reset asserted while a read grant is pending its response edge.
        s_vld = 8'h10;
        s_we  = '0;
        s_addr[4] = 6'd5;
        drive();
        #1;
        check("rst_mid_grant", bus.req_ready, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", bus.req_ready, 0);
        check("rst_mid_ram_we", bus.ram_we, 0);
        check("rst_mid_rsp_valid", bus.rsp_valid, 0);
        check("rst_mid_cnt", conflict_cnt, 0);
        for (int i = 0; i < N_REQ; i++) check("rst_mid_rdata", bus.rsp_rdata[i*WIDTH +: WIDTH], 0);
        @(posedge clk);
        #1;
        check("rst_mid_rsp_after_edge", bus.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        s_vld = 8'h10;
        step();
        check("resume_ready", last_ready, 8'h10);
        check("resume_rsp_valid", bus.rsp_valid, 8'h10);
        check("resume_rdata", bus.rsp_rdata[4*WIDTH +: WIDTH], 32'hDEAD_BEEF);

        // Randomized traffic on a small address window to provoke conflicts.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!s_vld[i] && $urandom_range(0, 9) < 6) begin
                    s_vld[i] = 1'b1;
                    if ($urandom_range(0, 9) == 0) begin
                        s_we[i]   = 1'b0;
                        s_addr[i] = AW'($urandom_range(48, 63));
                    end else begin
                        s_we[i]   = 1'($urandom_range(0, 1));
                        s_addr[i] = AW'($urandom_range(0, 7));
                    end
                    s_wdat[i] = $urandom();
                end
            end
            step();
        end
        s_vld = '0;
        step();
        for (int a = 0; a < 16; a++) check("final_mem", mem[a], m_mem[a]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
